// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the mux_arb round-robin
//                arbiter.
//                  arb_state_t : output-register occupancy state
//                  ARB_CNT_W   : width of the optional per-requester grant
//                                counters (MUX_ARB_PERF_EN builds only)
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int ARB_CNT_W = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,    // output register empty
        ARB_BUSY = 1'b1     // output register holds valid data
    } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/muxr.sv
`default_nettype none
// ============================================================================
//  Module      : muxr
//  Description : Plain 2**N_SEL : 1 data multiplexer.
//  Ports       : out   output [WIDTH-1:0]        selected word
//                sel   input  [N_SEL-1:0]        select index
//                d_in  input  [WIDTH-1:0] x 2**N_SEL candidate words
//  Revision    : 1.0 - initial release
// ============================================================================
module muxr #(
    parameter int N_SEL = 2,
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] out,
    input  logic [N_SEL-1:0] sel,
    input  logic [WIDTH-1:0] d_in [2**N_SEL]
);

    assign out = d_in[sel];

endmodule : muxr
`default_nettype wire

// File: rtl/mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb
//  Description : Round-robin arbiter feeding a single registered output
//                stage. One of N_REQ = 2**N_SEL requesters is granted per
//                cycle whenever the output register is empty or being
//                drained, giving full throughput under continuous demand.
//  Ports       : clk        input   clock, rising edge
//                rst        input   synchronous active-high reset
//                req_valid  input   [N_REQ]          request valid
//                req_data   input   [WIDTH] x N_REQ  request data
//                req_ready  output  [N_REQ]          one-hot grant (or zero)
//                out_valid  output                   output register full
//                out_ready  input                    downstream accept
//                out_data   output  [WIDTH]          granted data
//                out_sel    output  [N_SEL]          granted requester index
//                grant_cnt  output  [16] x N_REQ     saturating transfer
//                                                    counts (only when
//                                                    MUX_ARB_PERF_EN defined)
//  Config      : MUX_ARB_PERF_EN - adds grant_cnt and its counters
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb
    import arb_pkg::*;
#(
    parameter  int N_SEL = 2,
    parameter  int WIDTH = 32,
    localparam int N_REQ = 2**N_SEL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [WIDTH-1:0]     req_data [N_REQ],
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [N_SEL-1:0]     out_sel
`ifdef MUX_ARB_PERF_EN
    ,
    output logic [ARB_CNT_W-1:0] grant_cnt [N_REQ]
`endif
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_SEL-1:0] r_rr_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [N_SEL-1:0] r_out_sel;

    logic             w_load;
    logic             w_found;
    logic [N_SEL-1:0] w_gnt_idx;
    logic [N_SEL-1:0] w_scan_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_out;

    // The output register can accept a new word when it is empty or when
    // its current word leaves this cycle.
    assign w_load = (r_state == ARB_IDLE) | out_ready;

    // Round-robin search: first valid requester at or above rr_ptr, with the
    // index arithmetic wrapping naturally in N_SEL bits.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = r_rr_ptr;
        w_scan_idx = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = r_rr_ptr + N_SEL'(k);
            if (!w_found && req_valid[w_scan_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    // Reset gates the grant so nothing is accepted while rst is high.
    assign w_xfer = w_load & w_found & ~rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_xfer && (w_gnt_idx == N_SEL'(i));
        end
    end

    muxr #(
        .N_SEL (N_SEL),
        .WIDTH (WIDTH)
    ) u_muxr (
        .out  (w_mux_out),
        .sel  (w_gnt_idx),
        .d_in (req_data)
    );

    // Next state: a load either refills the register or empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_xfer ? ARB_BUSY : ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_out_data <= '0;
            r_out_sel  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_out_data <= w_mux_out;
                r_out_sel  <= w_gnt_idx;
                r_rr_ptr   <= w_gnt_idx + N_SEL'(1);
            end
        end
    end

    assign out_valid = (r_state == ARB_BUSY);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

`ifdef MUX_ARB_PERF_EN
    logic [ARB_CNT_W-1:0] r_grant_cnt [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                r_grant_cnt[gi] <= '0;
            end else if (req_ready[gi] && req_valid[gi] &&
                         (r_grant_cnt[gi] != {ARB_CNT_W{1'b1}})) begin
                r_grant_cnt[gi] <= r_grant_cnt[gi] + ARB_CNT_W'(1);
            end
        end
        assign grant_cnt[gi] = r_grant_cnt[gi];
    end
`endif

endmodule : mux_arb
`default_nettype wire
